// File: rtl/mag_comparator_iter_pkg.sv
// Shared definitions for the iterative magnitude comparator: FSM state
// encoding, chunk-count computation and the index-width helper.
package mag_comparator_iter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    // Result encoding used for the {eq, lt, gt} triple.
    localparam logic [2:0] RES_EQ = 3'b100;
    localparam logic [2:0] RES_LT = 3'b010;
    localparam logic [2:0] RES_GT = 3'b001;

    // Number of chunks an operand is split into.
    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Width of the chunk index register, never narrower than one bit.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/mag_comparator_iter_if.sv
// Start/busy/done handshake bundle between a requester (master) and the
// iterative comparator (slave).
interface mag_comparator_iter_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             lt;
    logic             gt;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, eq, lt, gt
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, eq, lt, gt
    );
endinterface

// File: rtl/mag_comparator_iter_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice; the multi-bit
// generalisation of the 1-bit eq/lt/gt cell.
module mag_comparator_iter_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    // Exactly one of eq/lt/gt is high for any pair of slices.
    always_comb begin
        eq = (a == b);
        lt = (a < b);
        gt = (a > b);
    end

endmodule

// File: rtl/mag_comparator_iter.sv
// Iterative WIDTH-bit magnitude comparator. Walks the operands CHUNK bits per
// cycle from the MSB chunk down and finishes at the first differing chunk.
// Signed compares are turned into unsigned ones by flipping the sign bit of
// both operands when they are latched.
module mag_comparator_iter
    import mag_comparator_iter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mag_comparator_iter_if.slave bus
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] IDX_MSB = IDXW'(NCHUNK - 1);

    generate
        if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
            $error("mag_comparator_iter: CHUNK must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              eq_q, eq_d;
    logic              lt_q, lt_d;
    logic              gt_q, gt_d;

    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic              chunk_eq;
    logic              chunk_lt;
    logic              chunk_gt;

    // Select the slice currently under comparison from both operand registers.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    mag_comparator_iter_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a  (a_chunk),
        .b  (b_chunk),
        .eq (chunk_eq),
        .lt (chunk_lt),
        .gt (chunk_gt)
    );

    // Next-state logic: accept a request in IDLE, then step one chunk per cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        eq_d    = eq_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d          = bus.a;
                    a_d[WIDTH-1] = bus.a[WIDTH-1] ^ bus.is_signed;
                    b_d          = bus.b;
                    b_d[WIDTH-1] = bus.b[WIDTH-1] ^ bus.is_signed;
                    idx_d        = IDX_MSB;
                    busy_d       = 1'b1;
                    state_d      = CMP;
                end
            end
            CMP: begin
                if (!chunk_eq) begin
                    eq_d    = 1'b0;
                    lt_d    = chunk_lt;
                    gt_d    = chunk_gt;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
        endcase
    end

    // State, operand and result registers; reset aborts any compare in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.eq   = eq_q;
    assign bus.lt   = lt_q;
    assign bus.gt   = gt_q;

endmodule

// File: tb/tb_mag_comparator_iter.sv
// Directed bench for the iterative magnitude comparator: a 4-bit-chunk
// instance for latency, handshake and reset behaviour, and a single-chunk
// instance compared against a behavioural signed/unsigned model.
module tb_mag_comparator_iter;

    localparam logic [2:0] R_EQ   = 3'b100;
    localparam logic [2:0] R_LT   = 3'b010;
    localparam logic [2:0] R_GT   = 3'b001;
    localparam logic [2:0] R_NONE = 3'b000;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [2:0] prev4;
    logic [2:0] prev16;

    mag_comparator_iter_if #(.WIDTH(16)) bus4 ();
    mag_comparator_iter_if #(.WIDTH(16)) bus16 ();

    mag_comparator_iter #(
        .WIDTH (16),
        .CHUNK (4)
    ) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    mag_comparator_iter #(
        .WIDTH (16),
        .CHUNK (16)
    ) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    function automatic logic [4:0] obs4();
        return {bus4.busy, bus4.done, bus4.eq, bus4.lt, bus4.gt};
    endfunction

    function automatic logic [4:0] obs16();
        return {bus16.busy, bus16.done, bus16.eq, bus16.lt, bus16.gt};
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [4:0] observed, input logic [4:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b (busy,done,eq,lt,gt)", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic sg, input logic [15:0] av, input logic [15:0] bv);
        bus4.start     = s;
        bus4.is_signed = sg;
        bus4.a         = av;
        bus4.b         = bv;
    endtask

    // Launch one compare on the 4-bit-chunk instance and check every cycle up to done.
    task automatic runCompare(input string tag, input logic sg, input logic [15:0] av,
                              input logic [15:0] bv, input int lat, input logic [2:0] exp_res,
                              input bit noisy);
        applyStimulus(1'b1, sg, av, bv);
        stepCycle();
        for (int i = 0; i < lat; i++) begin
            checkOutput($sformatf("%s_busy%0d", tag, i), obs4(), {2'b10, prev4});
            if (noisy) applyStimulus(1'b1, ~sg, 16'h0000, 16'hFFFF);
            else       applyStimulus(1'b0, sg, av, bv);
            stepCycle();
        end
        checkOutput($sformatf("%s_done", tag), obs4(), {2'b01, exp_res});
        prev4 = exp_res;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic idleCheck(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            stepCycle();
            checkOutput($sformatf("%s_idle%0d", tag, i), obs4(), {2'b00, prev4});
        end
    endtask

    initial begin
        logic [15:0] av;
        logic [15:0] bv;
        logic        sg;
        logic [2:0]  exp_res;

        clk    = 1'b0;
        rst    = 1'b1;
        total  = 0;
        bad    = 0;
        prev4  = R_NONE;
        prev16 = R_NONE;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        bus16.start     = 1'b0;
        bus16.is_signed = 1'b0;
        bus16.a         = 16'h0000;
        bus16.b         = 16'h0000;

        #12;
        checkOutput("reset4", obs4(), 5'b00000);
        checkOutput("reset16", obs16(), 5'b00000);
        stepCycle();
        rst = 1'b0;
        idleCheck("post_reset", 2);

        $display("[TB] equal operands, full latency");
        runCompare("t1_eq", 1'b0, 16'h1234, 16'h1234, 4, R_EQ, 1'b0);
        idleCheck("t1", 2);

        $display("[TB] sign handling on the MSB chunk");
        runCompare("t2_uns", 1'b0, 16'h8000, 16'h7FFF, 1, R_GT, 1'b0);
        idleCheck("t2a", 1);
        runCompare("t2_sgn", 1'b1, 16'h8000, 16'h7FFF, 1, R_LT, 1'b0);
        idleCheck("t2b", 1);

        $display("[TB] early exit at intermediate chunks");
        runCompare("t3_c2", 1'b0, 16'h1334, 16'h1234, 2, R_GT, 1'b0);
        idleCheck("t3a", 1);
        runCompare("t3_c0", 1'b0, 16'h1235, 16'h1234, 4, R_GT, 1'b0);

        $display("[TB] back-to-back start in the done cycle, then starts while busy");
        runCompare("t4_b2b", 1'b1, 16'hFFFF, 16'h0001, 1, R_LT, 1'b0);
        idleCheck("t4a", 1);
        runCompare("t4_noisy", 1'b0, 16'h1234, 16'h1243, 3, R_LT, 1'b1);
        idleCheck("t4b", 2);

        $display("[TB] reset during the second compare cycle");
        applyStimulus(1'b1, 1'b0, 16'h1234, 16'h1234);
        stepCycle();
        checkOutput("t5_busy0", obs4(), {2'b10, prev4});
        applyStimulus(1'b0, 1'b0, 16'h1234, 16'h1234);
        stepCycle();
        checkOutput("t5_busy1", obs4(), {2'b10, prev4});
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_now", obs4(), 5'b00000);
        stepCycle();
        rst   = 1'b0;
        prev4 = R_NONE;
        idleCheck("t5_quiet", 5);
        runCompare("t5_after", 1'b0, 16'h0001, 16'h0002, 4, R_LT, 1'b0);

        $display("[TB] single-chunk instance against reference model");
        for (int i = 0; i < 1000; i++) begin
            av = 16'($urandom);
            bv = (i % 8 == 0) ? av : 16'($urandom);
            sg = 1'($urandom_range(0, 1));
            if (av == bv)
                exp_res = R_EQ;
            else if (sg ? ($signed(av) < $signed(bv)) : (av < bv))
                exp_res = R_LT;
            else
                exp_res = R_GT;
            bus16.start     = 1'b1;
            bus16.is_signed = sg;
            bus16.a         = av;
            bus16.b         = bv;
            stepCycle();
            checkOutput($sformatf("t6_busy_%0d", i), obs16(), {2'b10, prev16});
            bus16.start = 1'b0;
            stepCycle();
            checkOutput($sformatf("t6_done_%0d_%h_%h_s%0d", i, av, bv, sg), obs16(), {2'b01, exp_res});
            prev16 = exp_res;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
